uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 177 +++++++++++++++++
 tb/tb_uart_rx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   UART 8N1 receiver. Oversamples the serial line with the system clock,
//   finds the middle of each bit from the start-bit falling edge and
//   recovers bytes LSB-first. Good bytes leave as a one-cycle strobe plus
//   data; a low stop bit produces a one-cycle framing-error strobe and no
//   byte. After a framing error (or reset) the receiver waits for the line
//   to go high before looking for another start bit, so a held-low break is
//   never decoded as a stream of 0x00 bytes.
//
// Parameters
//   CLKS_PER_BIT  system clocks per UART bit (legal 4..65535)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   rx_serial     asynchronous serial line, idle high
//   rx_dv         1-cycle strobe: rx_byte holds a newly received good byte
//   rx_byte[7:0]  last good byte, bit 0 = first data bit on the line
//   rx_frame_err  1-cycle strobe: stop bit sampled low
//   rx_busy       high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic       rx_dv,
  output logic [7:0] rx_byte,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] clk_cnt;
  logic [CNT_W-1:0] clk_cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;
  logic [7:0]       byte_nxt;
  logic             dv_nxt;
  logic             ferr_nxt;

  logic             rx_meta;
  logic             rx_sync;

  // Two-flop synchroniser for the asynchronous line. Both flops reset to the
  // idle level so that reset itself never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
    end
  end

  // State register plus all datapath registers. Every value is computed in
  // the next-state block below, so this block only loads or clears them.
  // The outputs are registered, which puts the strobes one cycle after the
  // stop-bit sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_HIGH;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_byte      <= '0;
      rx_dv        <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      clk_cnt      <= clk_cnt_nxt;
      bit_idx      <= bit_idx_nxt;
      shift        <= shift_nxt;
      rx_byte      <= byte_nxt;
      rx_dv        <= dv_nxt;
      rx_frame_err <= ferr_nxt;
    end
  end

  // Next-state and datapath logic. The start bit is checked half a bit after
  // the falling edge; from then on every sample lands one full bit later, so
  // data and stop bits are all taken near their midpoints. A start bit that
  // is high again at its midpoint is a glitch and is silently dropped.
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    byte_nxt    = rx_byte;
    dv_nxt      = 1'b0;
    ferr_nxt    = 1'b0;

    case (state)
      WAIT_HIGH: begin
        clk_cnt_nxt = '0;
        if (rx_sync) begin
          state_nxt = IDLE;
        end
      end

      IDLE: begin
        clk_cnt_nxt = '0;
        if (!rx_sync) begin
          state_nxt = START;
        end
      end

      START: begin
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_nxt = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_sync ? IDLE : DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end

      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt        = '0;
          shift_nxt[bit_idx] = rx_sync;
          bit_idx_nxt        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end

      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
          if (rx_sync) begin
            byte_nxt  = shift;
            dv_nxt    = 1'b1;
            state_nxt = IDLE;
          end else begin
            // A low stop bit may be the start of a break; wait for the line
            // to recover before hunting for the next start bit.
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = WAIT_HIGH;
      end
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Scoreboard bench for uart_rx. Two receivers are built, one with 16 clocks
//   per bit (lane 0) and one with 4 clocks per bit (lane 1), each on its own
//   serial line. Every frame sent pushes its expected outcome (byte or
//   framing error, and the exact cycle the strobe must appear) into the
//   lane's queue; an independent monitor pops and compares whenever a strobe
//   appears, and checks that rx_byte holds its last good value otherwise.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  typedef struct {
    logic [7:0] data;
    logic       is_err;
    int         cycle;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line16 = 1'b1;
  logic       line4 = 1'b1;

  logic       dv16, ferr16, busy16;
  logic [7:0] byte16;
  logic       dv4, ferr4, busy4;
  logic [7:0] byte4;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;

  exp_t       q16[$];
  exp_t       q4[$];
  logic [7:0] held[2] = '{8'h00, 8'h00};
  logic       prev_busy[2] = '{1'b1, 1'b1};

  uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk          (clk),
    .rst          (rst),
    .rx_serial    (line16),
    .rx_dv        (dv16),
    .rx_byte      (byte16),
    .rx_frame_err (ferr16),
    .rx_busy      (busy16)
  );

  uart_rx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .rx_serial    (line4),
    .rx_dv        (dv4),
    .rx_byte      (byte4),
    .rx_frame_err (ferr4),
    .rx_busy      (busy4)
  );

  // Free-running clock and a cycle counter that every expectation is
  // expressed against.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Sends one 8N1 frame on a lane, starting in the current cycle. When a
  // line is driven during cycle k, the synchroniser shows it in cycle k+2
  // (t0); the strobe is due one cycle after the stop sample at
  // t0+1+HALF+9*CPB. With noise on, data bits are only held stable within
  // one clock of their midpoint sample, which sits at offset 1+HALF within
  // each bit on the line.
  task automatic applyStimulus(input bit lane4, input logic [7:0] data,
                               input logic stop_bit, input bit noisy,
                               input bit push);
    int         cpb;
    int         half;
    int         k;
    logic [9:0] frame;
    exp_t       e;
    cpb   = lane4 ? 4 : 16;
    half  = (cpb - 1) / 2;
    k     = cyc;
    frame = {stop_bit, data, 1'b0};
    e.data   = data;
    e.is_err = ~stop_bit;
    e.cycle  = k + 2 + 1 + half + 9 * cpb + 1;
    if (push) begin
      if (lane4) q4.push_back(e);
      else       q16.push_back(e);
    end
    for (int c = 0; c < 10 * cpb; c++) begin
      int   b;
      int   off;
      logic v;
      b   = c / cpb;
      off = c % cpb;
      v   = frame[b];
      if (noisy && b >= 1 && b <= 8 && (off < half || off > half + 2)) begin
        v = logic'($urandom_range(0, 1));
      end
      if (lane4) line4 = v;
      else       line16 = v;
      waitCycle();
    end
  endtask

  // Per-lane monitor step, run at the falling edge. Reports missed strobes,
  // compares any strobe against the head of the queue, and otherwise checks
  // that rx_byte still holds the last good byte.
  task automatic monitorLane(input int lane, input logic dv, input logic ferr,
                             input logic busy, input logic [7:0] byt);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (lane == 0 && q16.size() > 0) begin e = q16[0]; have = 1'b1; end
    if (lane == 1 && q4.size() > 0)  begin e = q4[0];  have = 1'b1; end

    if (have && e.cycle < cyc && !(dv || ferr)) begin
      checkOutput($sformatf("lane%0d_missed_strobe", lane), cyc, e.cycle);
      if (lane == 0) void'(q16.pop_front());
      else           void'(q4.pop_front());
    end else if (dv || ferr) begin
      checkOutput($sformatf("lane%0d_dv_ferr_exclusive", lane), dv & ferr, 1'b0);
      if (!have) begin
        checkOutput($sformatf("lane%0d_unexpected_strobe", lane), {dv, ferr}, 2'b00);
      end else begin
        if (lane == 0) void'(q16.pop_front());
        else           void'(q4.pop_front());
        checkOutput($sformatf("lane%0d_strobe_cycle", lane), cyc, e.cycle);
        checkOutput($sformatf("lane%0d_strobe_is_ferr", lane), ferr, e.is_err);
        checkOutput($sformatf("lane%0d_busy_before_strobe", lane), prev_busy[lane], 1'b1);
        if (!e.is_err) begin
          checkOutput($sformatf("lane%0d_rx_byte", lane), byt, e.data);
          checkOutput($sformatf("lane%0d_busy_on_dv", lane), busy, 1'b0);
          held[lane] = e.data;
        end else begin
          checkOutput($sformatf("lane%0d_rx_byte_on_ferr", lane), byt, held[lane]);
          checkOutput($sformatf("lane%0d_busy_on_ferr", lane), busy, 1'b1);
        end
      end
    end else begin
      checkOutput($sformatf("lane%0d_rx_byte_hold", lane), byt, held[lane]);
    end
    prev_busy[lane] = busy;
    if (rst) held[lane] = 8'h00;
  endtask

  // Monitor process, decoupled from the stimulus.
  always @(negedge clk) begin
    if (mon_en) begin
      monitorLane(0, dv16, ferr16, busy16, byte16);
      monitorLane(1, dv4, ferr4, busy4, byte4);
    end
  end

  // Watchdog so the run always ends with a summary line.
  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int         k;
    logic [9:0] fr;
    exp_t       e;

    // Reset state
    repeat (3) waitCycle();
    @(negedge clk);
    checkOutput("reset_rx_byte16", byte16, 8'h00);
    checkOutput("reset_rx_dv16", dv16, 1'b0);
    checkOutput("reset_ferr16", ferr16, 1'b0);
    checkOutput("reset_busy16", busy16, 1'b1);
    checkOutput("reset_rx_byte4", byte4, 8'h00);
    mon_en = 1'b1;
    waitCycle();
    rst = 1'b0;
    repeat (4) waitCycle();
    @(negedge clk);
    checkOutput("idle_after_reset_busy16", busy16, 1'b0);
    checkOutput("idle_after_reset_busy4", busy4, 1'b0);
    waitCycle();

    $display("[TB] single frame 0xA5");
    applyStimulus(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1);
    repeat (20) waitCycle();

    $display("[TB] back-to-back 61 62 63 0D");
    applyStimulus(1'b0, 8'h61, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h62, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h63, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h0D, 1'b1, 1'b0, 1'b1);
    repeat (20) waitCycle();

    $display("[TB] start-bit glitch");
    k = cyc;
    line16 = 1'b0;
    repeat (4) waitCycle();
    line16 = 1'b1;
    waitCycle();
    @(negedge clk);
    checkOutput("glitch_busy_in_start", busy16, 1'b1);
    repeat (6) waitCycle();
    @(negedge clk);
    checkOutput("glitch_idle_by_t0_plus_9", busy16, 1'b0);
    checkOutput("glitch_elapsed_cycles", cyc - k, 11);
    waitCycle();
    repeat (16) waitCycle();
    applyStimulus(1'b0, 8'h3C, 1'b1, 1'b0, 1'b1);
    repeat (20) waitCycle();

    $display("[TB] framing error then break");
    applyStimulus(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    repeat (50) waitCycle();
    @(negedge clk);
    checkOutput("break_busy_held", busy16, 1'b1);
    repeat (50) waitCycle();
    line16 = 1'b1;
    repeat (8) waitCycle();
    @(negedge clk);
    checkOutput("break_released_busy", busy16, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 8'h3C, 1'b1, 1'b0, 1'b1);
    repeat (20) waitCycle();

    // Reset lands in data bit 3 of 0x96 (line cycles k+64..k+79), eight
    // cycles into the bit. The synchroniser restarts at the idle level, so
    // the FSM reaches IDLE and sees the still-low line as a start edge, but
    // the start-bit midpoint falls in data bit 4 (high): a glitch. The next
    // real falling edge is data bit 5 at k+96. Holding the line low after
    // the frame makes that false frame's stop bit low, so it ends as a
    // framing error rather than a byte.
    $display("[TB] reset mid-frame");
    k  = cyc;
    fr = {1'b1, 8'h96, 1'b0};
    e.data   = 8'h00;
    e.is_err = 1'b1;
    e.cycle  = k + 96 + 2 + 1 + 7 + 9 * 16 + 1;
    q16.push_back(e);
    for (int c = 0; c < 160; c++) begin
      line16 = fr[c / 16];
      if (c == 72) rst = 1'b1;
      if (c == 73) begin
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_rx_byte", byte16, 8'h00);
        checkOutput("post_reset_rx_dv", dv16, 1'b0);
        checkOutput("post_reset_ferr", ferr16, 1'b0);
      end
      waitCycle();
    end
    line16 = 1'b0;
    repeat (96) waitCycle();
    line16 = 1'b1;
    repeat (40) waitCycle();
    applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    repeat (20) waitCycle();

    $display("[TB] extremes and fast lane");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    repeat (8) waitCycle();
    applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
    repeat (8) waitCycle();

    $display("[TB] randomized noisy frames");
    for (int i = 0; i < 40; i++) begin
      bit         lane4;
      logic [7:0] d;
      logic       stop_ok;
      int         cpb;
      lane4   = bit'($urandom_range(0, 1));
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      cpb     = lane4 ? 4 : 16;
      applyStimulus(lane4, d, stop_ok, 1'b1, 1'b1);
      if (!stop_ok) begin
        if (lane4) line4 = 1'b1;
        else       line16 = 1'b1;
        repeat (3 * cpb) waitCycle();
      end else begin
        repeat ($urandom_range(0, cpb)) waitCycle();
      end
    end

    repeat (200) waitCycle();
    @(negedge clk);
    checkOutput("lane0_queue_drained", q16.size(), 0);
    checkOutput("lane1_queue_drained", q4.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
